// File: rtl/vga_pkg.sv
// Shared types and timing helpers for the VGA streaming output stage.
package vga_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        RUN    = 2'd1,
        RESYNC = 2'd2
    } state_t;

    localparam pixel_t BLACK = '0;

    function automatic int htotal(input int hdisp, input int hfp, input int hpulse, input int hbp);
        return hdisp + hfp + hpulse + hbp;
    endfunction

    function automatic int vtotal(input int vdisp, input int vfp, input int vpulse, input int vbp);
        return vdisp + vfp + vpulse + vbp;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Free-running pixel/line counters plus the stage-0 decode of active area,
// sync pulses and the frame_start / frame origin points.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 128,
    parameter int HBP    = 88,
    parameter int VFP    = 1,
    parameter int VPULSE = 4,
    parameter int VBP    = 23
) (
    input  logic clk,
    input  logic nrst,
    output logic active_o,
    output logic hs_n_o,
    output logic vs_n_o,
    output logic frame_start_pt_o,
    output logic origin_pt_o
);

    localparam int HTOTAL = htotal(HDISP, HFP, HPULSE, HBP);
    localparam int VTOTAL = vtotal(VDISP, VFP, VPULSE, VBP);
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);

    logic [HW-1:0] ct_h_q, ct_h_d;
    logic [VW-1:0] ct_v_q, ct_v_d;
    logic [31:0]   h, v;
    logic          h_last, v_last;

    assign h      = 32'(ct_h_q);
    assign v      = 32'(ct_v_q);
    assign h_last = (h == 32'(HTOTAL - 1));
    assign v_last = (v == 32'(VTOTAL - 1));

    // NOTE: next-state logic uses blocking '=' with a default first so no latch
    // can form; the registers below take only non-blocking '<='.
    always_comb begin
        ct_h_d = ct_h_q + HW'(1);
        ct_v_d = ct_v_q;
        if (h_last) begin
            ct_h_d = '0;
            ct_v_d = v_last ? '0 : ct_v_q + VW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            ct_h_q <= '0;
            ct_v_q <= '0;
        end else begin
            ct_h_q <= ct_h_d;
            ct_v_q <= ct_v_d;
        end
    end

    assign active_o         = (h < 32'(HDISP)) && (v < 32'(VDISP));
    assign hs_n_o           = !((h >= 32'(HDISP + HFP)) && (h < 32'(HDISP + HFP + HPULSE)));
    assign vs_n_o           = !((v >= 32'(VDISP + VFP)) && (v < 32'(VDISP + VFP + VPULSE)));
    assign frame_start_pt_o = (h == 32'd0) && (v == 32'(VDISP));
    assign origin_pt_o      = (h == 32'd0) && (v == 32'd0);

endmodule

// File: rtl/vga_stream_out.sv
// VGA output stage: pulls pixels from the framebuffer FIFO, drives sync/blank/rgb
// through a 2-cycle pipeline and resynchronises to the next frame on underflow.
module vga_stream_out
    import vga_pkg::*;
#(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 128,
    parameter int HBP    = 88,
    parameter int VFP    = 1,
    parameter int VPULSE = 4,
    parameter int VBP    = 23
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [23:0] fifo_rdata,
    input  logic        fifo_empty,
    input  logic        fifo_ready,
    output logic        fifo_rd,
    output logic        fifo_flush,
    output logic        frame_start,
    output logic        underflow,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank,
    output logic [23:0] vga_rgb
);

    logic active, hs_n, vs_n, fs_pt, origin;

    vga_timing_counter #(
        .HDISP (HDISP),
        .VDISP (VDISP),
        .HFP   (HFP),
        .HPULSE(HPULSE),
        .HBP   (HBP),
        .VFP   (VFP),
        .VPULSE(VPULSE),
        .VBP   (VBP)
    ) u_timing (
        .clk             (clk),
        .nrst            (nrst),
        .active_o        (active),
        .hs_n_o          (hs_n),
        .vs_n_o          (vs_n),
        .frame_start_pt_o(fs_pt),
        .origin_pt_o     (origin)
    );

    state_t state_q;
    logic   underflow_q;
    logic   engaged, starved;

    // WAIT hands over to RUN at the origin itself, so the first pixel is read that cycle.
    assign engaged = (state_q == RUN) || ((state_q == WAIT) && origin && fifo_ready);
    assign starved = engaged && active && fifo_empty;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= WAIT;
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_q | starved;
            case (state_q)
                WAIT: begin
                    if (starved)                  state_q <= RESYNC;
                    else if (origin && fifo_ready) state_q <= RUN;
                end
                RUN: begin
                    if (starved) state_q <= RESYNC;
                end
                RESYNC: begin
                    if (fs_pt) state_q <= WAIT;
                end
                default: state_q <= WAIT;
            endcase
        end
    end

    // Strobes are gated by nrst so they read as cleared for the whole reset.
    assign fifo_rd     = nrst && engaged && active && !fifo_empty;
    assign fifo_flush  = nrst && (state_q == RESYNC) && fs_pt;
    assign frame_start = nrst && fs_pt;
    assign underflow   = underflow_q;

    logic   s1_active_q, s1_hs_q, s1_vs_q, s1_rd_q;
    logic   hs_q, vs_q, blank_q;
    pixel_t rgb_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            s1_active_q <= 1'b0;
            s1_hs_q     <= 1'b1;
            s1_vs_q     <= 1'b1;
            s1_rd_q     <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            blank_q     <= 1'b0;
            rgb_q       <= BLACK;
        end else begin
            s1_active_q <= active;
            s1_hs_q     <= hs_n;
            s1_vs_q     <= vs_n;
            s1_rd_q     <= fifo_rd;
            hs_q        <= s1_hs_q;
            vs_q        <= s1_vs_q;
            blank_q     <= s1_active_q;
            rgb_q       <= s1_rd_q ? pixel_t'(fifo_rdata) : BLACK;
        end
    end

    assign vga_hs    = hs_q;
    assign vga_vs    = vs_q;
    assign vga_blank = blank_q;
    assign vga_rgb   = rgb_q;

endmodule

// File: tb/tb_vga_stream_out.sv
// Scoreboard bench for vga_stream_out on a scaled-down raster (32x14) so every
// scenario runs in a few thousand cycles.
module tb_vga_stream_out;
    import vga_pkg::*;

    localparam int HDISP = 20, VDISP = 8, HFP = 4, HPULSE = 6, HBP = 2;
    localparam int VFP = 1, VPULSE = 2, VBP = 3;
    localparam int HTOTAL = 32, VTOTAL = 14, FRAME = HTOTAL * VTOTAL;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic [23:0] rgb;
    } pins_t;

    localparam pins_t PINS_RST = {1'b1, 1'b1, 1'b0, 24'h000000};

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [23:0] fifo_rdata = 24'h0;
    logic        fifo_empty = 1'b0;
    logic        fifo_ready = 1'b0;
    logic        fifo_rd, fifo_flush, frame_start, underflow;
    logic        vga_hs, vga_vs, vga_blank;
    logic [23:0] vga_rgb;

    always #5 clk = ~clk;

    vga_stream_out #(
        .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_ready (fifo_ready),
        .fifo_rd    (fifo_rd),
        .fifo_flush (fifo_flush),
        .frame_start(frame_start),
        .underflow  (underflow),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_blank  (vga_blank),
        .vga_rgb    (vga_rgb)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [23:0] word(input int idx);
        return 24'(idx * 7 + 1);
    endfunction

    // Reference model state: counters for the current cycle, FSM, sticky flag.
    int     mh = 0, mv = 0;
    state_t mst = WAIT;
    logic   muf = 1'b0;
    pins_t  exp_q[$];
    int     exp_idx = 0, dut_idx = 0;
    logic   rd_seen = 1'b0;

    int   cyc = 0, hs_cnt = 0, vs_cnt = 0, b_rise = 0, last_fs = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1, prev_blank = 1'b0;
    logic hs_ok = 1'b0, vs_ok = 1'b0, b_ok = 1'b0, fs_ok = 1'b0;
    int   dut_reads = 0, m_reads = 0;

    int emp_h = -1, emp_v = -1, rst_h = -1, rst_v = -1;

    task automatic evaluate();
        logic  act, hsn, vsn, org, fsp, e_rd, e_fl, e_fs;
        pins_t got, want, nxt;
        act = (mh < HDISP) && (mv < VDISP);
        hsn = !((mh >= HDISP + HFP) && (mh < HDISP + HFP + HPULSE));
        vsn = !((mv >= VDISP + VFP) && (mv < VDISP + VFP + VPULSE));
        org = (mh == 0) && (mv == 0);
        fsp = (mh == 0) && (mv == VDISP);
        e_rd = 1'b0;
        if (nrst) begin
            case (mst)
                WAIT:    e_rd = org && fifo_ready && !fifo_empty;
                RUN:     e_rd = act && !fifo_empty;
                default: e_rd = 1'b0;
            endcase
        end
        e_fl = nrst && (mst == RESYNC) && fsp;
        e_fs = nrst && fsp;

        check("fifo_rd", 32'(fifo_rd), 32'(e_rd));
        check("fifo_flush", 32'(fifo_flush), 32'(e_fl));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("underflow", 32'(underflow), 32'(muf));
        rd_seen = fifo_rd;

        if (org) begin
            dut_reads = 0;
            m_reads   = 0;
        end
        if (fifo_rd) dut_reads++;
        if (e_rd) m_reads++;
        if (fsp && nrst && m_reads == HDISP * VDISP)
            check("reads_per_frame", 32'(dut_reads), 32'(HDISP * VDISP));

        got = {vga_hs, vga_vs, vga_blank, vga_rgb};
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("vga_hs", 32'(got.hs), 32'(want.hs));
            check("vga_vs", 32'(got.vs), 32'(want.vs));
            check("vga_blank", 32'(got.blank), 32'(want.blank));
            check("vga_rgb", 32'(got.rgb), 32'(want.rgb));
        end
        if (nrst) begin
            nxt = {hsn, vsn, act, (e_rd ? word(exp_idx) : 24'h0)};
            exp_q.push_back(nxt);
            if (e_rd) exp_idx++;
        end

        if (prev_hs && !got.hs) begin
            if (b_ok) check("blank_to_hs", 32'(cyc - b_rise), 32'(HDISP + HFP));
            b_ok   = 1'b0;
            hs_cnt = 1;
            hs_ok  = 1'b1;
        end else if (!got.hs) begin
            hs_cnt++;
        end else if (!prev_hs && hs_ok) begin
            check("hs_width", 32'(hs_cnt), 32'(HPULSE));
            hs_ok = 1'b0;
        end
        if (prev_vs && !got.vs) begin
            vs_cnt = 1;
            vs_ok  = 1'b1;
        end else if (!got.vs) begin
            vs_cnt++;
        end else if (!prev_vs && vs_ok) begin
            check("vs_width", 32'(vs_cnt), 32'(VPULSE * HTOTAL));
            vs_ok = 1'b0;
        end
        if (!prev_blank && got.blank) begin
            b_rise = cyc;
            b_ok   = 1'b1;
        end
        if (frame_start) begin
            if (fs_ok) check("fs_period", 32'(cyc - last_fs), 32'(FRAME));
            last_fs = cyc;
            fs_ok   = 1'b1;
        end
        prev_hs    = got.hs;
        prev_vs    = got.vs;
        prev_blank = got.blank;
        cyc++;

        if (!nrst) begin
            mh  = 0;
            mv  = 0;
            mst = WAIT;
            muf = 1'b0;
            exp_q.delete();
            exp_q.push_back(PINS_RST);
            exp_q.push_back(PINS_RST);
            hs_ok = 1'b0;
            vs_ok = 1'b0;
            b_ok  = 1'b0;
            fs_ok = 1'b0;
        end else begin
            case (mst)
                WAIT: if (org && fifo_ready) begin
                    if (fifo_empty) begin
                        mst = RESYNC;
                        muf = 1'b1;
                    end else begin
                        mst = RUN;
                    end
                end
                RUN: if (act && fifo_empty) begin
                    mst = RESYNC;
                    muf = 1'b1;
                end
                RESYNC: if (fsp) mst = WAIT;
                default: mst = WAIT;
            endcase
            if (mh == HTOTAL - 1) begin
                mh = 0;
                mv = (mv == VTOTAL - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
    endtask

    task automatic run(input int n, input logic rst_n_v, input logic rdy);
        for (int i = 0; i < n; i++) begin
            logic e, r;
            @(posedge clk);
            #1;
            if (rd_seen) begin
                fifo_rdata = word(dut_idx);
                dut_idx++;
            end
            e = (mh == emp_h) && (mv == emp_v);
            if (e) begin
                emp_h = -1;
                emp_v = -1;
            end
            r = (mh == rst_h) && (mv == rst_v);
            if (r) begin
                rst_h = -1;
                rst_v = -1;
            end
            nrst       = rst_n_v && !r;
            fifo_empty = e;
            fifo_ready = rdy;
            @(negedge clk);
            evaluate();
        end
    endtask

    initial begin
        exp_q.push_back(PINS_RST);
        exp_q.push_back(PINS_RST);

        run(30, 1'b0, 1'b0);
        run(2 * FRAME, 1'b1, 1'b0);
        run(2 * FRAME + 5, 1'b1, 1'b1);

        emp_h = 5;
        emp_v = 3;
        run(3 * FRAME, 1'b1, 1'b1);

        rst_h = 12;
        rst_v = 5;
        run(2 * FRAME, 1'b1, 1'b1);

        emp_h = HDISP - 1;
        emp_v = VDISP - 1;
        run(2 * FRAME, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
